// File: rtl/bp_btb_ras.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters plus a circular
// return-address stack that can be checkpointed and restored on mispredict.
module bp_btb_ras #(
    parameter int unsigned AW        = 48,
    parameter int unsigned BTB_SETS  = 256,
    parameter int unsigned RAS_DEPTH = 8,
    localparam int unsigned IW       = $clog2(BTB_SETS),
    localparam int unsigned PW       = $clog2(RAS_DEPTH),
    localparam int unsigned TW       = AW - IW - 2
) (
    input  logic              i_clk,
    input  logic              i_n_reset,
    input  logic              i_fetch_valid,
    input  logic [AW-1:0]     i_fetch_pc,
    input  logic [31:0]       i_fetch_instr,
    output logic [AW-1:0]     o_pred_pc,
    output logic              o_pred_taken,
    output logic [1:0]        o_pred_src,
    output logic [2*PW:0]     o_ras_ckpt,
    input  logic              i_upd_valid,
    input  logic [AW-1:0]     i_upd_pc,
    input  logic [AW-1:0]     i_upd_target,
    input  logic              i_upd_taken,
    input  logic              i_mispred,
    input  logic [2*PW:0]     i_mispred_ckpt,
    input  logic              i_mispred_is_call,
    input  logic              i_flush
);

    localparam logic [PW:0] RAS_FULL = (PW+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        SrcFall = 2'd0,
        SrcBtb  = 2'd1,
        SrcRas  = 2'd2
    } src_e;

    // BTB storage; only the valid bits are reset
    logic [BTB_SETS-1:0] r_valid;
    logic [TW-1:0]       r_tag    [BTB_SETS];
    logic [AW-1:0]       r_target [BTB_SETS];
    logic [1:0]          r_ctr    [BTB_SETS];

    // RAS storage; r_ptr is the next free slot, top of stack is r_ptr-1
    logic [AW-1:0]       r_ras [RAS_DEPTH];
    logic [PW-1:0]       r_ptr;
    logic [PW:0]         r_cnt;

    logic [PW-1:0]       w_ptr_d;
    logic [PW:0]         w_cnt_d;
    logic                w_ras_we;
    logic [PW-1:0]       w_ras_widx;
    logic [AW-1:0]       w_ras_wdata;

    logic [6:0]          w_opc;
    logic [4:0]          w_rd;
    logic [4:0]          w_rs1;
    logic [2:0]          w_f3;
    logic                w_rd_link;
    logic                w_rs1_link;
    logic                w_push;
    logic                w_pop;
    logic                w_repl;

    logic [IW-1:0]       w_f_idx;
    logic [TW-1:0]       w_f_tag;
    logic                w_f_hit;
    logic [IW-1:0]       w_u_idx;
    logic [TW-1:0]       w_u_tag;
    logic                w_u_hit;

    logic [PW-1:0]       w_top_idx;
    logic [AW-1:0]       w_link_pc;
    logic [PW-1:0]       w_ck_ptr;
    logic [PW:0]         w_ck_cnt;
    logic                w_unused;

    assign w_opc      = i_fetch_instr[6:0];
    assign w_rd       = i_fetch_instr[11:7];
    assign w_f3       = i_fetch_instr[14:12];
    assign w_rs1      = i_fetch_instr[19:15];
    assign w_rd_link  = (w_rd == 5'd1) || (w_rd == 5'd5);
    assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
    assign w_unused   = ^i_fetch_instr[31:20];

    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_repl = 1'b0;
        if (i_fetch_valid) begin
            if (w_opc == 7'h6f) begin
                w_push = w_rd_link;
            end else if (w_opc == 7'h67 && w_f3 == 3'd0) begin
                unique case ({w_rd_link, w_rs1_link})
                    2'b01:   w_pop  = 1'b1;
                    2'b10:   w_push = 1'b1;
                    2'b11: begin
                        // coroutine swap when the link registers differ
                        w_push = (w_rd == w_rs1);
                        w_repl = (w_rd != w_rs1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_f_idx   = i_fetch_pc[IW+1:2];
    assign w_f_tag   = i_fetch_pc[AW-1:IW+2];
    assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_u_idx   = i_upd_pc[IW+1:2];
    assign w_u_tag   = i_upd_pc[AW-1:IW+2];
    assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    assign w_top_idx = r_ptr - PW'(1);
    assign w_link_pc = i_fetch_pc + AW'(4);
    assign w_ck_ptr  = i_mispred_ckpt[2*PW:PW+1];
    assign w_ck_cnt  = i_mispred_ckpt[PW:0];

    always_comb begin
        o_pred_pc  = w_link_pc;
        o_pred_src = SrcFall;
        if (i_n_reset) begin
            if ((w_pop || w_repl) && r_cnt != '0) begin
                o_pred_pc  = r_ras[w_top_idx];
                o_pred_src = SrcRas;
            end else if (w_f_hit && r_ctr[w_f_idx][1]) begin
                o_pred_pc  = r_target[w_f_idx];
                o_pred_src = SrcBtb;
            end
        end
    end

    assign o_pred_taken = (o_pred_src != SrcFall);
    assign o_ras_ckpt   = {r_ptr, r_cnt};

    always_comb begin
        w_ptr_d     = r_ptr;
        w_cnt_d     = r_cnt;
        w_ras_we    = 1'b0;
        w_ras_widx  = r_ptr;
        w_ras_wdata = w_link_pc;
        if (i_flush) begin
            w_ptr_d = '0;
            w_cnt_d = '0;
        end else if (i_mispred) begin
            w_ptr_d = w_ck_ptr;
            w_cnt_d = w_ck_cnt;
            if (i_mispred_is_call) begin
                w_ras_we    = 1'b1;
                w_ras_widx  = w_ck_ptr;
                w_ras_wdata = i_upd_pc + AW'(4);
                w_ptr_d     = w_ck_ptr + PW'(1);
                w_cnt_d     = (w_ck_cnt >= RAS_FULL) ? RAS_FULL : w_ck_cnt + 1'b1;
            end
        end else if (w_push || (w_repl && r_cnt == '0)) begin
            // a replace on an empty stack degenerates to a plain push
            w_ras_we = 1'b1;
            w_ptr_d  = r_ptr + PW'(1);
            w_cnt_d  = (r_cnt >= RAS_FULL) ? RAS_FULL : r_cnt + 1'b1;
        end else if (w_repl) begin
            w_ras_we   = 1'b1;
            w_ras_widx = w_top_idx;
        end else if (w_pop && r_cnt != '0) begin
            w_ptr_d = w_top_idx;
            w_cnt_d = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            r_ptr <= w_ptr_d;
            r_cnt <= w_cnt_d;
            if (w_ras_we) begin
                r_ras[w_ras_widx] <= w_ras_wdata;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            r_valid <= '0;
        end else if (i_upd_valid) begin
            if (w_u_hit) begin
                if (i_upd_taken) begin
                    r_target[w_u_idx] <= i_upd_target;
                    if (r_ctr[w_u_idx] != 2'd3) begin
                        r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
                    end
                end else if (r_ctr[w_u_idx] != 2'd0) begin
                    r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
                end
            end else if (i_upd_taken) begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= i_upd_target;
                r_ctr[w_u_idx]    <= 2'd2;
            end
        end
    end

endmodule
